hdmi_clock_reset_seq: RTL

- Consumer-side companion to the HDMI clock generator.
- Runs on the pixel clock (25.2 MHz) and watches the PLL lock flag.
- Sequences resets for the TMDS serializers and the pixel-domain logic, in that order, once lock has been stable long enough.
- Re-enters reset on lock loss and reports a link-ready flag to the video timing generator.

---
 rtl/hdmi_pkg.sv | 23 ++
 rtl/hdmi_bit_sync.sv | 31 +++
 rtl/hdmi_clock_reset_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI clock/reset sequencer.
// The state encoding and counter sizing live here so related blocks agree on them.
package hdmi_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    SER_REL = 2'd2,
    RUN     = 2'd3
  } hdmi_state_e;

  localparam int unsigned LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int unsigned SER_TO_PIX_DELAY_DEF   = 16;

  // One counter serves both timed states, so it is sized for the longer interval.
  // It only ever holds (interval - 1), hence clog2 of the interval itself.
  function automatic int hdmi_cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hdmi_bit_sync.sv
// N-stage single-bit synchroniser with asynchronous active-high reset.
// Generic enough for any slow CDC flag; STAGES must be at least 2.
module hdmi_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: flops use non-blocking assignments so every stage samples the
  // value its neighbour held before the edge, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hdmi_clock_reset_seq.sv
// Pixel-domain reset sequencer: releases serializer then pixel reset after PLL lock settles.
// Define HDMI_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module hdmi_clock_reset_seq
  import hdmi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned SER_TO_PIX_DELAY   = SER_TO_PIX_DELAY_DEF,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_in,
  input  logic                  restart_req,
  output logic                  ser_rst,
  output logic                  pix_rst,
  output logic                  link_ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = hdmi_cnt_w(LOCK_STABLE_CYCLES, SER_TO_PIX_DELAY);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SER_LAST    = CNT_W'(SER_TO_PIX_DELAY - 1);

  logic             lock_s;
  hdmi_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_rst_q, ser_rst_d;
  logic             pix_rst_q, pix_rst_d;
  logic             link_ready_q, link_ready_d;

  hdmi_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_in),
    .q   (lock_s)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        cnt_d = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s || restart_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = SER_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SER_REL: begin
        if (!lock_s || restart_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == SER_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s || restart_req) state_d = HOLD;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    // Decoding from the next state keeps outputs registered yet aligned with the state.
    ser_rst_d    = (state_d == HOLD) || (state_d == STABLE);
    pix_rst_d    = (state_d != RUN);
    link_ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      ser_rst_q    <= 1'b1;
      pix_rst_q    <= 1'b1;
      link_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ser_rst_q    <= ser_rst_d;
      pix_rst_q    <= pix_rst_d;
      link_ready_q <= link_ready_d;
    end
  end

  assign ser_rst    = ser_rst_q;
  assign pix_rst    = pix_rst_q;
  assign link_ready = link_ready_q;

`ifdef HDMI_LOCK_LOSS_CNT_EN
  // Lock loss wins over a coincident restart, so only lock_s matters here.
  logic                  loss_evt;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  assign loss_evt = (state_q == RUN) && !lock_s;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
